// File: rtl/ps_stream_arbiter_pkg.sv
// ps_arb_pkg: shared state type and round-robin pick helper for PacketStream schedulers
package ps_arb_pkg;
  localparam int MAX_COUNT = 32;
  localparam int IDX_W = $clog2(MAX_COUNT);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } pick_t;
  function automatic pick_t rr_pick(input logic [MAX_COUNT-1:0] req, input int ptr, input int count);
    pick_t p;
    int k;
    p = '0;
    // scan downwards so the nearest requester after ptr is the one left standing
    for (int i = MAX_COUNT; i >= 1; i--) begin
      k = ptr + i;
      k = k >= count ? k - count : k;
      if (i <= count && req[k[IDX_W-1:0]]) p = '{vld: 1'b1, idx: k[IDX_W-1:0]};
    end
    return p;
  endfunction
endpackage

// File: rtl/ps_stream_arbiter_if.sv
// ps_stream_arbiter_if: COUNT PacketStream inputs sharing one PacketStream output
interface ps_stream_arbiter_if #(parameter int WIDTH = 8, parameter int COUNT = 4);
  localparam int SEL_W = $clog2(COUNT);
  logic [COUNT*WIDTH-1:0] i_dat;
  logic [COUNT-1:0]       i_val;
  logic [COUNT-1:0]       i_eop;
  logic [COUNT-1:0]       i_rdy;
  logic [WIDTH-1:0]       o_dat;
  logic [SEL_W-1:0]       o_sel;
  logic                   o_val;
  logic                   o_eop;
  logic                   o_rdy;
  modport master (output i_dat, i_val, i_eop, o_rdy, input i_rdy, o_dat, o_sel, o_val, o_eop);
  modport slave (input i_dat, i_val, i_eop, o_rdy, output i_rdy, o_dat, o_sel, o_val, o_eop);
endinterface

// File: rtl/ps_skid_buffer.sv
// ps_skid_buffer: 2-entry register slice with registered full flag
module ps_skid_buffer #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_val,
  output logic             full,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_val,
  input  logic             out_rdy
);
  logic [WIDTH-1:0] d0, d1;
  logic [1:0] cnt, cnt_n, lvl;
  logic wr, rd;
  assign rd = out_val & out_rdy;
  assign wr = in_val & ~full;
  assign lvl = cnt - {1'b0, rd};
  assign cnt_n = lvl + {1'b0, wr};
  assign out_dat = d0;
  assign out_val = cnt != 2'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d0 <= '0;
      d1 <= '0;
      cnt <= '0;
      full <= 1'b0;
    end else begin
      d0 <= wr && lvl == 2'd0 ? in_dat : rd ? d1 : d0;
      d1 <= wr && lvl == 2'd1 ? in_dat : d1;
      cnt <= cnt_n;
      full <= cnt_n == 2'd2;
    end
endmodule

// File: rtl/ps_stream_arbiter.sv
// ps_stream_arbiter: packet-granular round-robin PacketStream multiplexer with skid-buffered output
module ps_stream_arbiter import ps_arb_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input logic clk,
  input logic reset,
  ps_stream_arbiter_if.slave s
);
  localparam int SEL_W = $clog2(COUNT);
  localparam int PW = WIDTH + 1 + SEL_W;
  state_t state, state_n;
  logic [SEL_W-1:0] grant, grant_n, ptr, ptr_n;
  logic [WIDTH-1:0] dat;
  logic full, busy, xfer;
  pick_t pick;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      ptr <= SEL_W'(COUNT - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr <= ptr_n;
    end
  assign busy = state == BUSY;
  assign xfer = busy & s.i_val[grant] & ~full;
  assign dat = s.i_dat[grant*WIDTH +: WIDTH];
  assign s.i_rdy = busy & ~full ? COUNT'(1) << grant : '0;
  always_comb begin
    pick = rr_pick(MAX_COUNT'(s.i_val), int'(ptr), COUNT);
    state_n = state;
    grant_n = grant;
    ptr_n = ptr;
    if (!busy && pick.vld) begin
      state_n = BUSY;
      grant_n = SEL_W'(pick.idx);
    end
    if (xfer && s.i_eop[grant]) begin
      state_n = IDLE;
      ptr_n = grant;
    end
  end
  ps_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk(clk),
    .reset(reset),
    .in_dat({s.i_eop[grant], grant, dat}),
    .in_val(xfer),
    .full(full),
    .out_dat({s.o_eop, s.o_sel, s.o_dat}),
    .out_val(s.o_val),
    .out_rdy(s.o_rdy)
  );
endmodule
